seven_seg_scan_ctrl: RTL and testbench
======================================

SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

Interface
REQ-001 The block SHALL have parameter DIV, default 50000, meaning clock cycles each digit is lit (legal range 1..2^20-1).
REQ-002 The block SHALL have parameter BLANK, default 16, meaning all-anodes-off clock cycles before each digit (legal range 1..255).
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 The block SHALL have port en  input  1  scan enable; 0 forces the display dark.
REQ-006 The block SHALL have port load  input  1  request to capture new display data.
REQ-007 The block SHALL have port data_in  input  16  four BCD digits; [3:0] is digit 0, [15:12] is digit 3.
REQ-008 The block SHALL have port dp_in  input  4  decimal point per digit; bit n belongs to digit n, 1 = lit.
REQ-009 The block SHALL have port ready  output  1  1 = load is accepted this cycle.
REQ-010 The block SHALL have port anode  output  4  one-hot, active-high digit enable; bit n drives digit n.
REQ-011 The block SHALL have port cathode  output  8  active-low segments {a,b,c,d,e,f,g,dp}, bit 7 = a, bit 0 = dp.
REQ-012 The block SHALL have port digit_sel  output  2  index of the digit currently scanned.
REQ-013 The block SHALL have port frame_done  output  1  one-cycle pulse at the end of each digit-3 lit window.

Function
REQ-014 All outputs SHALL be registered.
REQ-015 FSM states: IDLE, BLANK, SHOW.
- IDLE: en=1 goes to BLANK with digit_sel=0.
- BLANK: after BLANK cycles, goes to SHOW.
- SHOW: after DIV cycles, goes to BLANK with digit_sel+1, wrapping 3->0.
REQ-016 In IDLE and BLANK, anode SHALL be 4'b0000 and cathode SHALL be 8'hFF.
REQ-017 In SHOW, anode SHALL be 1<<digit_sel and cathode SHALL be the segment code of the active digit, with cathode[0] = ~dp.
REQ-018 Segment codes (cathode[7:1], active-low, a..g):
- 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
- 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
- 10..15 = 1111111 (dark)
REQ-019 Timing SHALL be exact: anode nonzero for exactly DIV cycles per digit, zero for exactly BLANK cycles between digits; frame period = 4*(DIV+BLANK) cycles.
REQ-020 frame_done SHALL be 1 for exactly the cycle after the last SHOW cycle of digit 3, and 0 otherwise.
REQ-021 Handshake:
- ready=1 whenever no update is pending.
- load&&ready captures data_in/dp_in into a pending register; ready=0 from the next cycle.
- load while ready=0 SHALL be ignored; pending data is not overwritten.
REQ-022 Commit: pending data SHALL copy to the active display registers at the digit-3->digit-0 transition, or on the cycle after capture while in IDLE; ready=1 on the following cycle.
- A digit never changes value mid-frame (no tearing).
REQ-023 A load accepted on the same cycle as a frame boundary SHALL commit at the next boundary, not the current one.
REQ-024 en deasserted in any state SHALL enter IDLE on the next edge, with anode=0 and the scan counters cleared.
- Pending data is retained.
- Re-enable restarts at BLANK, digit 0.
REQ-025 Counters SHALL be wide enough for the maximum legal parameter values and SHALL never wrap within a window.

Reset
REQ-026 rst=1 SHALL immediately, without waiting for clk, force:
- state=IDLE, anode=0, cathode=8'hFF, digit_sel=0, frame_done=0, ready=1
- active data 16'hFFFF (dark), dp 4'b0000, no update pending
REQ-027 Reset asserted mid-frame or mid-handshake SHALL discard pending data.
- After release with en=1, scan SHALL start at BLANK, digit 0, on the first edge.

Verification (DIV=4, BLANK=2)
REQ-028 Reset, en=1, then load data_in=16'h4321, dp_in=4'b0010 in IDLE -> each frame shows:
- anode 0001 with cathode 10011111
- anode 0010 with cathode 00100100
- anode 0100 with cathode 00001101
- anode 1000 with cathode 10011001
REQ-029 Free-running scan -> anode pattern 0,0,X,X,X,X repeating with X = 0001, 0010, 0100, 1000; frame_done pulses every 24 cycles.
REQ-030 Load 16'h9999 mid-frame while showing 16'h1111 -> the current frame completes with all 1s, 9s appear from the next digit 0, and ready stays low until after commit.
REQ-031 Second load while ready=0 with data 16'h5555 -> ignored; the first pending value commits.
REQ-032 data_in=16'hABCD -> all digits show cathode 8'hFF in SHOW.
REQ-033 rst pulsed mid-SHOW of digit 2 -> anode=0 asynchronously, before the next clk edge; after release, the display is dark (16'hFFFF) and the scan restarts at digit 0.

Source files
------------

// File: rtl/seven_seg_scan_ctrl.sv
// rtl/seven_seg_scan_ctrl.sv - multiplexed 4-digit seven-segment scan controller
// Blanked digit scan with tear-free double-buffered display data.
module seven_seg_scan_ctrl #(
    parameter int DIV   = 50000,
    parameter int BLANK = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] data_in,
    input  logic [3:0]  dp_in,
    output logic        ready,
    output logic [3:0]  anode,
    output logic [7:0]  cathode,
    output logic [1:0]  digit_sel,
    output logic        frame_done
);

    localparam int CW = 20;

    typedef enum logic [1:0] {S_IDLE, S_BLANK, S_SHOW} state_t;

    state_t       state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]   digit_q, digit_d;
    logic [15:0]  pend_q, pend_d;
    logic [3:0]   pend_dp_q, pend_dp_d;
    logic         pend_valid_q, pend_valid_d;
    logic [15:0]  act_q, act_d;
    logic [3:0]   act_dp_q, act_dp_d;
    logic [3:0]   anode_q, anode_d;
    logic [7:0]   cathode_q, cathode_d;
    logic         frame_done_q, frame_done_d;
    logic         ready_q, ready_d;
    logic         last_show;
    logic         frame_end;
    logic         commit;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'd0:    seg7 = 7'b0000001;
            4'd1:    seg7 = 7'b1001111;
            4'd2:    seg7 = 7'b0010010;
            4'd3:    seg7 = 7'b0000110;
            4'd4:    seg7 = 7'b1001100;
            4'd5:    seg7 = 7'b0100100;
            4'd6:    seg7 = 7'b0100000;
            4'd7:    seg7 = 7'b0001111;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0000100;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        digit_d      = digit_q;
        pend_d       = pend_q;
        pend_dp_d    = pend_dp_q;
        pend_valid_d = pend_valid_q;
        act_d        = act_q;
        act_dp_d     = act_dp_q;

        last_show = (state_q == S_SHOW) && (cnt_q == CW'(DIV - 1));
        frame_end = last_show && (digit_q == 2'd3) && en;

        if (!en) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            digit_d = 2'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_BLANK;
                    cnt_d   = '0;
                    digit_d = 2'd0;
                end
                S_BLANK: begin
                    if (cnt_q == CW'(BLANK - 1)) begin
                        state_d = S_SHOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_SHOW: begin
                    if (last_show) begin
                        state_d = S_BLANK;
                        cnt_d   = '0;
                        digit_d = digit_q + 2'd1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    digit_d = 2'd0;
                end
            endcase
        end

        // A capture on a boundary edge only sets pend_valid_q afterwards, so it waits a frame.
        commit = pend_valid_q && ((state_q == S_IDLE) || frame_end);
        if (commit) begin
            act_d        = pend_q;
            act_dp_d     = pend_dp_q;
            pend_valid_d = 1'b0;
        end else if (load && ready_q) begin
            pend_d       = data_in;
            pend_dp_d    = dp_in;
            pend_valid_d = 1'b1;
        end

        ready_d      = !pend_valid_d;
        frame_done_d = frame_end;

        // Outputs are computed from next state so the registered pins line up with state_q.
        if (state_d == S_SHOW) begin
            anode_d   = 4'b0001 << digit_d;
            cathode_d = {seg7(act_d[{digit_d, 2'b00} +: 4]), ~act_dp_d[digit_d]};
        end else begin
            anode_d   = 4'b0000;
            cathode_d = 8'hFF;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            digit_q      <= 2'd0;
            pend_q       <= 16'hFFFF;
            pend_dp_q    <= 4'b0000;
            pend_valid_q <= 1'b0;
            act_q        <= 16'hFFFF;
            act_dp_q     <= 4'b0000;
            anode_q      <= 4'b0000;
            cathode_q    <= 8'hFF;
            frame_done_q <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            digit_q      <= digit_d;
            pend_q       <= pend_d;
            pend_dp_q    <= pend_dp_d;
            pend_valid_q <= pend_valid_d;
            act_q        <= act_d;
            act_dp_q     <= act_dp_d;
            anode_q      <= anode_d;
            cathode_q    <= cathode_d;
            frame_done_q <= frame_done_d;
            ready_q      <= ready_d;
        end
    end

    assign ready      = ready_q;
    assign anode      = anode_q;
    assign cathode    = cathode_q;
    assign digit_sel  = digit_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb/tb_seven_seg_scan_ctrl.sv - directed self-checking bench for seven_seg_scan_ctrl
module tb_seven_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        load;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic        ready;
    logic [3:0]  anode;
    logic [7:0]  cathode;
    logic [1:0]  digit_sel;
    logic        frame_done;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [31:0] CATH_4321 = 32'h990D249F;
    localparam logic [31:0] CATH_1111 = 32'h9F9F9F9F;
    localparam logic [31:0] CATH_9999 = 32'h09090909;
    localparam logic [31:0] CATH_DARK = 32'hFFFFFFFF;

    seven_seg_scan_ctrl #(.DIV(4), .BLANK(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .ready      (ready),
        .anode      (anode),
        .cathode    (cathode),
        .digit_sel  (digit_sel),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One frame = 4 x (2 blank + 4 show) = 24 cycles; k indexes cycles from the frame start.
    task automatic run_frame(input string tag, input logic [31:0] cath, input bit fd0,
                             input int ncyc, input int lk1, input logic [15:0] ld1,
                             input logic [3:0] dp1, input int lk2, input logic [15:0] ld2,
                             input int rlo_from, input int rlo_to);
        for (int k = 0; k < ncyc; k++) begin
            int d;
            int ph;
            logic [3:0] exp_an;
            logic [7:0] exp_ca;
            @(posedge clk);
            @(negedge clk);
            d  = k / 6;
            ph = k % 6;
            exp_an = (ph < 2) ? 4'b0000 : (4'b0001 << d);
            exp_ca = (ph < 2) ? 8'hFF : cath[8*d +: 8];
            check_eq($sformatf("%s.anode[%0d]", tag, k), {28'd0, anode}, {28'd0, exp_an});
            check_eq($sformatf("%s.cathode[%0d]", tag, k), {24'd0, cathode}, {24'd0, exp_ca});
            check_eq($sformatf("%s.digit_sel[%0d]", tag, k), {30'd0, digit_sel}, d);
            check_eq($sformatf("%s.frame_done[%0d]", tag, k), {31'd0, frame_done},
                     (k == 0 && fd0) ? 1 : 0);
            check_eq($sformatf("%s.ready[%0d]", tag, k), {31'd0, ready},
                     (k >= rlo_from && k <= rlo_to) ? 0 : 1);
            load = 1'b0;
            if (k == lk1) begin
                load = 1'b1; data_in = ld1; dp_in = dp1;
            end else if (k == lk2) begin
                load = 1'b1; data_in = ld2; dp_in = 4'b0000;
            end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; load = 1'b0; data_in = 16'h0000; dp_in = 4'b0000;
        #12;
        check_eq("rst.anode", {28'd0, anode}, 0);
        check_eq("rst.cathode", {24'd0, cathode}, 32'hFF);
        check_eq("rst.digit_sel", {30'd0, digit_sel}, 0);
        check_eq("rst.frame_done", {31'd0, frame_done}, 0);
        check_eq("rst.ready", {31'd0, ready}, 1);

        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        load = 1'b1; data_in = 16'h4321; dp_in = 4'b0010;
        @(posedge clk);
        @(negedge clk);
        load = 1'b0;
        check_eq("idle.ready_low", {31'd0, ready}, 0);
        @(posedge clk);
        @(negedge clk);
        check_eq("idle.ready_back", {31'd0, ready}, 1);
        check_eq("idle.anode", {28'd0, anode}, 0);
        check_eq("idle.cathode", {24'd0, cathode}, 32'hFF);
        en = 1'b1;

        run_frame("f1", CATH_4321, 1'b0, 24, -1, 16'h0, 4'h0, -1, 16'h0, 99, 99);
        run_frame("f2", CATH_4321, 1'b1, 24, -1, 16'h0, 4'h0, -1, 16'h0, 99, 99);
        // load on the last show cycle is captured at the boundary edge and must wait a frame
        run_frame("f3", CATH_4321, 1'b1, 24, 23, 16'h1111, 4'h0, -1, 16'h0, 99, 99);
        run_frame("f4", CATH_4321, 1'b1, 24, -1, 16'h0, 4'h0, -1, 16'h0, 0, 23);
        run_frame("f5", CATH_1111, 1'b1, 24, 8, 16'h9999, 4'h0, 14, 16'h5555, 9, 23);
        run_frame("f6", CATH_9999, 1'b1, 24, 3, 16'hABCD, 4'h0, -1, 16'h0, 4, 23);
        run_frame("f7", CATH_DARK, 1'b1, 24, 5, 16'h1111, 4'h0, -1, 16'h0, 6, 23);
        run_frame("f8", CATH_1111, 1'b1, 16, 4, 16'h2222, 4'h0, -1, 16'h0, 5, 23);

        #2;
        rst = 1'b1;
        #1;
        check_eq("arst.anode", {28'd0, anode}, 0);
        check_eq("arst.cathode", {24'd0, cathode}, 32'hFF);
        check_eq("arst.digit_sel", {30'd0, digit_sel}, 0);
        check_eq("arst.ready", {31'd0, ready}, 1);
        @(negedge clk);
        rst = 1'b0;

        run_frame("f9", CATH_DARK, 1'b0, 24, 2, 16'h4321, 4'b0010, -1, 16'h0, 3, 23);
        run_frame("f10", CATH_4321, 1'b1, 10, -1, 16'h0, 4'h0, -1, 16'h0, 99, 99);
        en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("en_off.anode", {28'd0, anode}, 0);
        check_eq("en_off.cathode", {24'd0, cathode}, 32'hFF);
        check_eq("en_off.digit_sel", {30'd0, digit_sel}, 0);
        check_eq("en_off.frame_done", {31'd0, frame_done}, 0);
        @(posedge clk);
        @(negedge clk);
        check_eq("en_off.anode2", {28'd0, anode}, 0);
        en = 1'b1;
        run_frame("f11", CATH_4321, 1'b0, 24, -1, 16'h0, 4'h0, -1, 16'h0, 99, 99);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
